// File: rtl/grey_frame_sequencer_pkg.sv
// Shared definitions for the grey frame sequencer.
//   - seq_state_e : frame FSM states (IDLE/RUN/DRAIN/DONE)
//   - IMG_W_DEF / IMG_H_DEF : default image geometry
//   - RGB_W / GREY_W : source and result pixel widths
//   - INFL_W : width of the converter in-flight counter (MAX_INFLIGHT <= 15)
//   - clog2_min1 : counter width helper that never returns 0
package grey_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int RGB_W     = 12;
  localparam int GREY_W    = 4;
  localparam int INFL_W    = 4;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/grey_frame_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings.
//   source side : src_rd_en, src_addr (out) / src_rd_data (in, one cycle after strobe)
//   converter   : cvt_pixel_in, cvt_in_ready (out) / cvt_pixel_out, cvt_out_ready (in)
//   destination : dst_wr_en, dst_addr, dst_wr_data, out_sof, out_eol (out) / dst_stall (in)
// master = sequencer, slave = memories and converter.
interface grey_frame_sequencer_if
  import grey_seq_pkg::*;
#(
  parameter int ADDR_W = 19
) ();

  logic                src_rd_en;
  logic [ADDR_W-1:0]   src_addr;
  logic [RGB_W-1:0]    src_rd_data;

  logic [RGB_W-1:0]    cvt_pixel_in;
  logic                cvt_in_ready;
  logic [GREY_W-1:0]   cvt_pixel_out;
  logic                cvt_out_ready;

  logic                dst_wr_en;
  logic [ADDR_W-1:0]   dst_addr;
  logic [GREY_W-1:0]   dst_wr_data;
  logic                out_sof;
  logic                out_eol;
  logic                dst_stall;

  modport master (
    output src_rd_en, src_addr,
    input  src_rd_data,
    output cvt_pixel_in, cvt_in_ready,
    input  cvt_pixel_out, cvt_out_ready,
    output dst_wr_en, dst_addr, dst_wr_data, out_sof, out_eol,
    input  dst_stall
  );

  modport slave (
    input  src_rd_en, src_addr,
    output src_rd_data,
    input  cvt_pixel_in, cvt_in_ready,
    output cvt_pixel_out, cvt_out_ready,
    input  dst_wr_en, dst_addr, dst_wr_data, out_sof, out_eol,
    output dst_stall
  );

endinterface

// File: rtl/grey_frame_sequencer_raster_counter.sv
// Raster-order position counter (x, y and linear address) for one frame.
//   clk, rst      : clock, asynchronous active-low reset
//   clr           : return to pixel 0 (wins over inc)
//   inc           : advance one pixel; wraps to 0 after the last pixel
//   x, y, addr    : current position
//   last_col      : x is the last column of a line
//   last_pix      : current position is the last pixel of the frame
module raster_counter
  import grey_seq_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 19,
  parameter int X_W    = clog2_min1(IMG_W),
  parameter int Y_W    = clog2_min1(IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last_pix,
  output logic              last_col
);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign last_col = (x_q == X_W'(IMG_W - 1));
  assign last_pix = last_col && (y_q == Y_W'(IMG_H - 1));

  // The linear address is kept as its own counter so no y*IMG_W multiply is needed.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr || (inc && last_pix)) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (inc) begin
      addr_d = addr_q + ADDR_W'(1);
      if (last_col) begin
        x_d = '0;
        y_d = y_q + Y_W'(1);
      end else begin
        x_d = x_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign addr = addr_q;

endmodule

// File: rtl/grey_frame_sequencer.sv
// Frame sequencer: walks the RGB444 source frame in raster order, feeds the
// rgb_to_grey converter and writes the grey results to the destination store.
//   clk, rst : clock, asynchronous active-low reset
//   start    : begin one frame (only honoured in IDLE)
//   busy     : frame in progress (RUN or DRAIN)
//   done     : one-cycle pulse after the final destination write
//   err      : sticky, converter returned a result nobody asked for
//   bus      : source / converter / destination signals (master side)
module grey_frame_sequencer
  import grey_seq_pkg::*;
#(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int ADDR_W       = 19,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  grey_frame_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;
  localparam int X_W = clog2_min1(IMG_W);
  localparam int Y_W = clog2_min1(IMG_H);

  logic [1:0]        state_q, state_d;
  logic [INFL_W-1:0] infl_q, infl_d;
  logic              err_q, err_d;
  logic              wr_done_q, wr_done_d;
  logic              in_vld_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [GREY_W-1:0] wr_data_q;
  logic              sof_q, eol_q;

  logic              start_acc, rd_issue, res_active, res_ok, res_bad;
  logic [X_W-1:0]    rd_x, wr_x;
  logic [Y_W-1:0]    rd_y, wr_y;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic              rd_last_pix, rd_last_col, wr_last_pix, wr_last_col;
  logic              unused_rd;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign rd_issue   = (state_q == S_RUN) && !bus.dst_stall &&
                      (infl_q < INFL_W'(MAX_INFLIGHT));
  assign res_active = (state_q == S_RUN) || (state_q == S_DRAIN);
  // A result is only accepted while a frame is active and something is outstanding.
  assign res_ok     = bus.cvt_out_ready && res_active && (infl_q != '0);
  assign res_bad    = bus.cvt_out_ready && !res_ok;

  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_rd_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(rd_issue),
    .x(rd_x), .y(rd_y), .addr(rd_addr), .last_pix(rd_last_pix), .last_col(rd_last_col)
  );

  raster_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_wr_cnt (
    .clk(clk), .rst(rst), .clr(start_acc), .inc(res_ok),
    .x(wr_x), .y(wr_y), .addr(wr_addr), .last_pix(wr_last_pix), .last_col(wr_last_col)
  );

  // The read side only needs the linear address and the end-of-frame flag.
  assign unused_rd = ^{rd_x, rd_y, rd_last_col};

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (rd_issue && rd_last_pix) state_d = S_DRAIN;
      // wr_done_q rises with the final write strobe, so DONE lands one cycle later.
      S_DRAIN: if (wr_done_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    infl_d = infl_q;
    if (start_acc) begin
      infl_d = '0;
    end else begin
      case ({rd_issue, res_ok})
        2'b10:   infl_d = infl_q + INFL_W'(1);
        2'b01:   infl_d = infl_q - INFL_W'(1);
        default: infl_d = infl_q;
      endcase
    end
  end

  always_comb begin
    err_d     = start_acc ? 1'b0 : (err_q | res_bad);
    wr_done_d = wr_done_q | (res_ok && wr_last_pix);
    if (start_acc || (state_q == S_DONE)) wr_done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      infl_q    <= '0;
      err_q     <= 1'b0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      infl_q    <= infl_d;
      err_q     <= err_d;
      wr_done_q <= wr_done_d;
    end
  end

  // Stage boundary: source read strobe -> converter input valid (data arrives with it).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_vld_q <= 1'b0;
    else      in_vld_q <= rd_issue;
  end

  // Stage boundary: converter result -> registered destination write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
    end else begin
      wr_en_q <= res_ok;
      sof_q   <= res_ok && (wr_x == '0) && (wr_y == '0);
      eol_q   <= res_ok && wr_last_col;
      if (res_ok) begin
        wr_addr_q <= wr_addr;
        wr_data_q <= bus.cvt_pixel_out;
      end
    end
  end

  assign bus.src_rd_en    = rd_issue;
  assign bus.src_addr     = rd_addr;
  assign bus.cvt_in_ready = in_vld_q;
  // Gated so the converter input reads as zero whenever it is not qualified.
  assign bus.cvt_pixel_in = in_vld_q ? bus.src_rd_data : '0;
  assign bus.dst_wr_en    = wr_en_q;
  assign bus.dst_addr     = wr_addr_q;
  assign bus.dst_wr_data  = wr_data_q;
  assign bus.out_sof      = sof_q;
  assign bus.out_eol      = eol_q;

  assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_grey_frame_sequencer.sv
module tb_grey_frame_sequencer;
  import grey_seq_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int AW   = 19;
  localparam int MAXI = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done, err;

  always #5 clk = ~clk;

  grey_frame_sequencer_if #(.ADDR_W(AW)) bus ();

  grey_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .err(err),
    .bus(bus)
  );

  // ---------------- environment: source memory and converter model ----------------
  logic [11:0] src_mem [NPIX];
  logic [11:0] mem_q = '0;
  int          lat_cfg = 1;
  logic        stall = 1'b0;
  logic        spur = 1'b0;
  logic        rand_mode = 1'b0;
  logic [11:0] rnd_src = '0;
  logic [3:0]  rnd_px = '0;
  logic        rnd_ordy = 1'b0;
  logic        cv_v [8];
  logic [3:0]  cv_d [8];

  function automatic logic [3:0] grey_of(input logic [11:0] p);
    int s;
    s = int'(p[11:8]) + 2 * int'(p[7:4]) + int'(p[3:0]);
    return 4'(s / 4);
  endfunction

  always @(posedge clk) begin
    if (bus.src_rd_en) mem_q <= src_mem[bus.src_addr[2:0]];
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        cv_v[i] <= 1'b0;
        cv_d[i] <= '0;
      end
    end else begin
      cv_v[0] <= bus.cvt_in_ready;
      cv_d[0] <= grey_of(bus.cvt_pixel_in);
      for (int i = 1; i < 8; i++) begin
        cv_v[i] <= cv_v[i-1];
        cv_d[i] <= cv_d[i-1];
      end
    end
  end

  assign bus.src_rd_data   = rand_mode ? rnd_src : mem_q;
  assign bus.cvt_out_ready = rand_mode ? rnd_ordy : (cv_v[lat_cfg-1] | spur);
  assign bus.cvt_pixel_out = rand_mode ? rnd_px : (spur ? 4'hF : cv_d[lat_cfg-1]);
  assign bus.dst_stall     = stall;

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({busy, done, err, bus.src_rd_en, bus.src_addr, bus.cvt_pixel_in,
                bus.cvt_in_ready, bus.dst_wr_en, bus.dst_addr, bus.dst_wr_data,
                bus.out_sof, bus.out_eol});
  endfunction

  // Runs one frame from start; the expected write stream is pixel i -> address i,
  // data grey_of(src_mem[i]), sof at pixel 0, eol at the end of each line.
  task automatic run_frame(input int lat, input int st_lo, input int st_hi,
                           input bit rnd, input bit mid_start,
                           output int n_wr, output int n_rd, output int n_done,
                           output bit err_end);
    int  infl, last_wr_cyc, post, prev_addr;
    bit  prev_rd, seen_done;
    n_wr = 0; n_rd = 0; n_done = 0; infl = 0; last_wr_cyc = -10;
    post = 0; prev_addr = 0; prev_rd = 1'b0; seen_done = 1'b0;
    lat_cfg = lat;
    @(negedge clk);
    start = 1'b1;
    stall = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        start = mid_start && (cyc == 3);
        stall = rnd ? ($urandom_range(0, 2) == 0) : (cyc >= st_lo && cyc <= st_hi);
      end
      #1;
      if (cyc == 1) begin
        chk("busy_after_start", busy, 1);
        chk("err_clear_after_start", err, 0);
      end
      chk("cvt_in_ready_delay", bus.cvt_in_ready, prev_rd);
      if (bus.cvt_in_ready) chk("cvt_pixel_in", bus.cvt_pixel_in, src_mem[prev_addr]);
      if (bus.src_rd_en) begin
        chk("no_read_when_stalled", stall, 0);
        chk("src_addr", bus.src_addr, n_rd);
        prev_addr = n_rd % NPIX;
        n_rd++;
      end
      prev_rd = bus.src_rd_en;
      infl = infl + int'(bus.src_rd_en) - int'(bus.cvt_out_ready);
      chk("inflight_le_max", (infl <= MAXI) ? 1 : 0, 1);
      if (bus.dst_wr_en) begin
        chk("dst_addr", bus.dst_addr, n_wr);
        chk("dst_wr_data", bus.dst_wr_data, grey_of(src_mem[n_wr % NPIX]));
        chk("out_sof", bus.out_sof, (n_wr == 0) ? 1 : 0);
        chk("out_eol", bus.out_eol, ((n_wr % W) == W - 1) ? 1 : 0);
        n_wr++;
        last_wr_cyc = cyc;
      end else begin
        chk("sof_eol_only_with_write", {bus.out_sof, bus.out_eol}, 0);
      end
      if (done) begin
        n_done++;
        chk("done_one_after_last_write", cyc - last_wr_cyc, 1);
        chk("busy_low_with_done", busy, 0);
        seen_done = 1'b1;
      end
      if (seen_done) begin
        post++;
        if (post > 6) break;
      end
    end
    if (!seen_done) chk("frame_timeout", 0, 1);
    err_end = err;
    stall = 1'b0;
    start = 1'b0;
  endtask

  typedef struct {
    int lat;        // 0 = random 1..6
    int st_lo;
    int st_hi;
    bit rnd;        // random stall and random source pixels
    bit mid_start;
    int exp_wr;
    int exp_rd;
    int exp_done;
    bit exp_err;
  } vec_t;

  task automatic load_src(input bit rnd);
    for (int j = 0; j < NPIX; j++)
      src_mem[j] = rnd ? 12'($urandom) : 12'(12'h111 * j);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int n_wr,
                             input int n_rd, input int n_done, input bit e);
    chk({tag, "_writes"}, n_wr, v.exp_wr);
    chk({tag, "_reads"}, n_rd, v.exp_rd);
    chk({tag, "_dones"}, n_done, v.exp_done);
    chk({tag, "_err"}, e, v.exp_err);
  endtask

  initial begin
    vec_t tbl [8];
    vec_t plain;
    int   n_wr, n_rd, n_done, lat, got;
    bit   e;

    tbl[0] = '{1, -1, -1, 1'b0, 1'b0, NPIX, NPIX, 1, 1'b0};
    tbl[1] = '{1,  3,  6, 1'b0, 1'b0, NPIX, NPIX, 1, 1'b0};
    tbl[2] = '{5, -1, -1, 1'b0, 1'b0, NPIX, NPIX, 1, 1'b0};
    tbl[3] = '{1, -1, -1, 1'b0, 1'b1, NPIX, NPIX, 1, 1'b0};
    tbl[4] = '{0, -1, -1, 1'b1, 1'b0, NPIX, NPIX, 1, 1'b0};
    tbl[5] = '{0, -1, -1, 1'b1, 1'b0, NPIX, NPIX, 1, 1'b0};
    tbl[6] = '{0, -1, -1, 1'b1, 1'b1, NPIX, NPIX, 1, 1'b0};
    tbl[7] = '{0, -1, -1, 1'b1, 1'b0, NPIX, NPIX, 1, 1'b0};
    plain  = tbl[0];

    // Reset held with random activity on every input.
    load_src(1'b0);
    rand_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rnd_src  = 12'($urandom);
      rnd_px   = 4'($urandom);
      rnd_ordy = 1'($urandom);
      start    = 1'($urandom);
      stall    = 1'($urandom);
      #1;
      chk("outputs_zero_in_reset", outs_vec(), 0);
    end
    @(negedge clk);
    rand_mode = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("outputs_zero_idle", outs_vec(), 0);
    end

    // Table of frames.
    for (int i = 0; i < 8; i++) begin
      load_src(tbl[i].rnd);
      lat = (tbl[i].lat == 0) ? int'($urandom_range(1, 6)) : tbl[i].lat;
      run_frame(lat, tbl[i].st_lo, tbl[i].st_hi, tbl[i].rnd, tbl[i].mid_start,
                n_wr, n_rd, n_done, e);
      check_frame($sformatf("frame%0d", i), tbl[i], n_wr, n_rd, n_done, e);
      repeat (2) @(negedge clk);
    end

    // Spurious converter result while idle: sets err, writes nothing.
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    #1;
    chk("spurious_sets_err", err, 1);
    chk("spurious_no_write", bus.dst_wr_en, 0);
    @(negedge clk);
    #1;
    chk("err_sticky", err, 1);
    chk("spurious_no_write_later", bus.dst_wr_en, 0);
    load_src(1'b0);
    run_frame(1, -1, -1, 1'b0, 1'b0, n_wr, n_rd, n_done, e);
    check_frame("after_spurious", plain, n_wr, n_rd, n_done, e);

    // Reset in the middle of a frame after three writes.
    load_src(1'b1);
    lat_cfg = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got < 3; c++) begin
      @(negedge clk);
      #1;
      if (bus.dst_wr_en) got++;
    end
    chk("reached_three_writes", got, 3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_outputs_zero", outs_vec(), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("no_done_in_abort", done, 0);
      chk("abort_outputs_stay_zero", outs_vec(), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(2, -1, -1, 1'b0, 1'b0, n_wr, n_rd, n_done, e);
    check_frame("after_abort", plain, n_wr, n_rd, n_done, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
